rcb_frl_delay_train_ctrl: RTL and testbench
===========================================

Name: rcb_frl_delay_train_ctrl

Overview:
Training controller for the Fast Radio Link receive path. It drives the count/ud control pair of the 7-bit input-delay tap counter that feeds the IDELAY tap value. It sweeps the tap 0..127, compares deserialized words against the training pattern, and finds the widest-qualifying data eye. It then steps the tap back to the eye centre and reports done or fail.

Parameters:
PATTERN, 8'h5C, expected training word on data_in
SETTLE_CYC, 7, idle cycles after any tap change before sampling (1..255)
SAMPLE_CNT, 16, consecutive matching words needed for a tap to pass (1..255)
MIN_EYE, 4, minimum passing-tap run accepted as an eye (1..128)

Ports:
clk  in  1  link clock
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; begins training
data_in  in  8  deserialized receive word, one per clk
count  out  1  tap counter enable (registered)
ud  out  1  tap counter direction/hold (registered)
tap_est  out  7  controller's mirror of the tap value
eye_width  out  8  width of the accepted eye (0..128)
busy  out  1  training in progress
done  out  1  sticky; training succeeded
fail  out  1  sticky; no qualifying eye found

Behaviour:
- Downstream encoding of {count,ud}: 00 = clear to 0, 01 = hold, 10 = decrement, 11 = increment. Each non-hold code lasts exactly one cycle. The default output is 01.
- Reset (asynchronous, any state): count=0, ud=1, tap_est=0, eye_width=0, busy=0, done=0, fail=0, FSM=IDLE, all internal counters 0.
- tap_est updates on the same edge that drives the code, so it leads the downstream counter by one cycle.
- FSM states:
  - IDLE: waits for start. On start: busy=1, done=0, fail=0, go to CLEAR.
  - CLEAR: drive 00 for one cycle, tap_est=0, eye_start=0, in_eye=0. Go to SETTLE.
  - SETTLE: hold for SETTLE_CYC cycles, then go to SAMPLE.
  - SAMPLE: compare data_in to PATTERN each cycle. The first mismatch aborts with tap fail. SAMPLE_CNT consecutive matches gives tap pass. Go to EVAL.
  - EVAL, on pass:
    - If !in_eye: eye_start=tap_est, in_eye=1.
    - If tap_est<127: go to STEP.
    - Else: eye_end=128, go to RESOLVE.
  - EVAL, on fail:
    - If in_eye: eye_end=tap_est, go to RESOLVE.
    - Else if tap_est<127: go to STEP.
    - Else: go to FAILED.
  - RESOLVE: width = eye_end - eye_start (8-bit).
    - If width < MIN_EYE: in_eye=0, then STEP if tap_est<127, else FAILED.
    - Else: eye_width=width, centre = eye_start + (width>>1) (7-bit; never exceeds 127), go to CENTER.
  - STEP: drive 11 for one cycle, tap_est+1, go to SETTLE. Never entered at tap_est=127; no wrap to 0.
  - CENTER: drive 10 on consecutive cycles, decrementing tap_est, until tap_est==centre (zero decrements if already equal). Then go to DONE.
  - DONE: busy=0, done=1, hold code 01. Go to IDLE.
  - FAILED: drive 00 for one cycle, tap_est=0, eye_width=0, busy=0, fail=1. Go to IDLE.
- start while busy is ignored. start in IDLE after done/fail clears both flags and retrains.
- The first qualifying eye (lowest taps) is accepted. Later eyes are not searched.
- The code 11 is never emitted with tap_est=127. The code 10 is never emitted with tap_est=0.

Test Plan:
1. Data model passes only for taps 40..59 (else PATTERN^8'h01); pulse start → tap sweeps 0..60, eye_start=40, eye_end=60, eye_width=20, 10 decrements (60→50), done=1, tap_est=50, downstream counter=50.
2. Pass taps 100..127 → no 11 code at tap 127, eye_end=128, eye_width=28, centre=114, 13 decrements, done=1.
3. Always mismatch → 127 increments then one 00 code, fail=1, tap_est=0, eye_width=0, busy=0.
4. Pass taps 10..12 and 30..45, MIN_EYE=4 → glitch run (width 3) discarded, eye_width=16, centre=38, done=1.
5. Single mismatch injected at the 16th sample of tap 40 in scenario 1 → tap 40 fails, eye_start=41, eye_width=19, centre=50.
6. Assert rst for 2 cycles mid-CENTER, then start while busy → all outputs at reset values immediately (count=0, ud=1). After release, a start issued while busy is ignored; a fresh start reruns scenario 1 to tap 50.

Source files
------------

// File: rtl/rcb_frl_delay_train_ctrl_if.sv
// Control/status bundle between the FRL delay-training controller and its user.
// The master side issues start and supplies the deserialized receive word.
// The slave side (the controller) drives the tap-counter code and training status.
interface rcb_frl_delay_train_ctrl_if;
    logic       start;      // single-cycle pulse, begins training
    logic [7:0] data_in;    // deserialized receive word, one per clk
    logic       count;      // tap counter enable
    logic       ud;         // tap counter direction / hold
    logic [6:0] tap_est;    // controller's mirror of the tap value
    logic [7:0] eye_width;  // width of the accepted eye
    logic       busy;
    logic       done;
    logic       fail;

    modport master (
        output start,
        output data_in,
        input  count,
        input  ud,
        input  tap_est,
        input  eye_width,
        input  busy,
        input  done,
        input  fail
    );

    modport slave (
        input  start,
        input  data_in,
        output count,
        output ud,
        output tap_est,
        output eye_width,
        output busy,
        output done,
        output fail
    );
endinterface

// File: rtl/rcb_frl_delay_train_ctrl.sv
// FRL receive-path delay training controller.
// Sweeps the 7-bit IDELAY tap from 0 upward, qualifies each tap against the
// training word, accepts the first passing run of at least MIN_EYE taps and
// then walks the tap back down to the centre of that run.
// Tap counter code {count,ud}: 00 clear, 01 hold, 10 decrement, 11 increment.
module rcb_frl_delay_train_ctrl #(
    parameter logic [7:0]  PATTERN    = 8'h5C,
    parameter int unsigned SETTLE_CYC = 7,
    parameter int unsigned SAMPLE_CNT = 16,
    parameter int unsigned MIN_EYE    = 4
) (
    input logic                       clk,
    input logic                       rst,
    rcb_frl_delay_train_ctrl_if.slave bus
);

    localparam logic [7:0] SettleLast = 8'(SETTLE_CYC - 1);
    localparam logic [7:0] SampleLast = 8'(SAMPLE_CNT - 1);
    localparam logic [7:0] MinEye     = 8'(MIN_EYE);
    localparam logic [6:0] TapTop     = 7'd127;

    typedef enum logic [3:0] {
        StIdle,
        StClear,
        StSettle,
        StSample,
        StEval,
        StResolve,
        StStep,
        StCenter,
        StDone,
        StFailed
    } state_e;

    state_e     r_state;
    logic       r_count;
    logic       r_ud;
    logic [6:0] r_tap;
    logic [7:0] r_eye_width;
    logic       r_busy;
    logic       r_done;
    logic       r_fail;
    logic [7:0] r_settle_cnt;
    logic [7:0] r_sample_cnt;
    logic       r_pass;
    logic       r_in_eye;
    logic [6:0] r_eye_start;
    logic [7:0] r_eye_end;      // 8 bits so an eye running off the top can end at 128
    logic [6:0] r_centre;

    logic       w_match;
    logic       w_at_top;
    logic [7:0] w_width;
    logic [6:0] w_centre;

    // Per-cycle decode of the sampled word and the candidate eye geometry.
    always_comb begin
        w_match  = (bus.data_in == PATTERN);
        w_at_top = (r_tap == TapTop);
        w_width  = r_eye_end - {1'b0, r_eye_start};
        // start + width/2 stays below 128 because the eye ends at most at 128
        w_centre = r_eye_start + w_width[7:1];
    end

    // Training sequencer; every output comes straight from a register here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_count      <= 1'b0;
            r_ud         <= 1'b1;
            r_tap        <= 7'd0;
            r_eye_width  <= 8'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_settle_cnt <= 8'd0;
            r_sample_cnt <= 8'd0;
            r_pass       <= 1'b0;
            r_in_eye     <= 1'b0;
            r_eye_start  <= 7'd0;
            r_eye_end    <= 8'd0;
            r_centre     <= 7'd0;
        end else begin
            // Hold code unless a state below issues a one-cycle command.
            r_count <= 1'b0;
            r_ud    <= 1'b1;

            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_fail  <= 1'b0;
                        r_state <= StClear;
                    end
                end

                StClear: begin
                    r_count      <= 1'b0;
                    r_ud         <= 1'b0;
                    r_tap        <= 7'd0;
                    r_eye_start  <= 7'd0;
                    r_in_eye     <= 1'b0;
                    r_settle_cnt <= 8'd0;
                    r_state      <= StSettle;
                end

                StSettle: begin
                    if (r_settle_cnt == SettleLast) begin
                        r_sample_cnt <= 8'd0;
                        r_state      <= StSample;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 8'd1;
                    end
                end

                StSample: begin
                    if (!w_match) begin
                        r_pass  <= 1'b0;
                        r_state <= StEval;
                    end else if (r_sample_cnt == SampleLast) begin
                        r_pass  <= 1'b1;
                        r_state <= StEval;
                    end else begin
                        r_sample_cnt <= r_sample_cnt + 8'd1;
                    end
                end

                StEval: begin
                    if (r_pass) begin
                        if (!r_in_eye) begin
                            r_eye_start <= r_tap;
                            r_in_eye    <= 1'b1;
                        end
                        if (!w_at_top) begin
                            r_state <= StStep;
                        end else begin
                            // eye still open at the last tap: close it one past the end
                            r_eye_end <= 8'd128;
                            r_state   <= StResolve;
                        end
                    end else if (r_in_eye) begin
                        r_eye_end <= {1'b0, r_tap};
                        r_state   <= StResolve;
                    end else if (!w_at_top) begin
                        r_state <= StStep;
                    end else begin
                        r_state <= StFailed;
                    end
                end

                StResolve: begin
                    if (w_width < MinEye) begin
                        // too narrow: discard and keep sweeping from the failing tap
                        r_in_eye <= 1'b0;
                        r_state  <= w_at_top ? StFailed : StStep;
                    end else begin
                        r_eye_width <= w_width;
                        r_centre    <= w_centre;
                        r_state     <= StCenter;
                    end
                end

                StStep: begin
                    if (!w_at_top) begin
                        r_count <= 1'b1;
                        r_ud    <= 1'b1;
                        r_tap   <= r_tap + 7'd1;
                    end
                    r_settle_cnt <= 8'd0;
                    r_state      <= StSettle;
                end

                StCenter: begin
                    // centre never lies above the current tap, so only decrements occur
                    if (r_tap != r_centre) begin
                        r_count <= 1'b1;
                        r_ud    <= 1'b0;
                        r_tap   <= r_tap - 7'd1;
                    end else begin
                        r_state <= StDone;
                    end
                end

                StDone: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= StIdle;
                end

                StFailed: begin
                    r_count     <= 1'b0;
                    r_ud        <= 1'b0;
                    r_tap       <= 7'd0;
                    r_eye_width <= 8'd0;
                    r_busy      <= 1'b0;
                    r_fail      <= 1'b1;
                    r_state     <= StIdle;
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.count     = r_count;
    assign bus.ud        = r_ud;
    assign bus.tap_est   = r_tap;
    assign bus.eye_width = r_eye_width;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.fail      = r_fail;

endmodule

// File: tb/tb_rcb_frl_delay_train_ctrl.sv
// Bench for rcb_frl_delay_train_ctrl: models the downstream tap counter and a
// receive path whose word is correct only on chosen taps, then compares each
// training run against an eye search computed directly from the tap pass map.
module tb_rcb_frl_delay_train_ctrl;

    localparam logic [7:0] PATTERN    = 8'h5C;
    localparam int         SETTLE_CYC = 7;
    localparam int         SAMPLE_CNT = 16;
    localparam int         MIN_EYE    = 4;
    localparam int         RUN_BUDGET = 8000;

    typedef struct packed {
        logic       done;
        logic       fail;
        logic       busy;
        logic [7:0] width;
        logic [6:0] tap;
        logic [6:0] ds;
        logic [7:0] incs;
        logic [7:0] decs;
        logic [7:0] clrs;
        logic [7:0] viols;
    } outcome_t;

    logic clk = 1'b0;
    logic rst;

    rcb_frl_delay_train_ctrl_if bus_if ();

    rcb_frl_delay_train_ctrl #(
        .PATTERN    (PATTERN),
        .SETTLE_CYC (SETTLE_CYC),
        .SAMPLE_CNT (SAMPLE_CNT),
        .MIN_EYE    (MIN_EYE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    bit drive_map [128];   // taps where the receive path delivers PATTERN
    bit model_map [128];   // taps the reference model treats as passing
    int inj_tap   = -1;    // tap carrying one corrupted word
    int inj_dwell = 0;

    int ds_cur = 0;        // downstream tap counter value during this cycle
    int dwell  = 0;        // cycles ds_cur has held its value
    bit desync = 1'b1;
    int n_inc  = 0;
    int n_dec  = 0;
    int n_clr  = 0;
    int n_viol = 0;
    int s_inc, s_dec, s_clr, s_viol;

    // Receive path and downstream counter: word follows the real tap, and the
    // counter applies the code the controller presents for this cycle.
    always @(negedge clk) begin
        int ds_nxt;
        if (drive_map[ds_cur] && !(ds_cur == inj_tap && dwell == inj_dwell))
            bus_if.data_in = PATTERN;
        else
            bus_if.data_in = PATTERN ^ 8'($urandom_range(1, 255));
        case ({bus_if.count, bus_if.ud})
            2'b00: begin ds_nxt = 0; n_clr++; desync = 1'b0; end
            2'b10: begin if (ds_cur == 0) n_viol++; ds_nxt = ds_cur - 1; n_dec++; end
            2'b11: begin if (ds_cur == 127) n_viol++; ds_nxt = ds_cur + 1; n_inc++; end
            default: ds_nxt = ds_cur;
        endcase
        ds_nxt = ds_nxt & 127;
        if (rst) desync = 1'b1;
        else if (!desync && ds_nxt != int'(bus_if.tap_est)) n_viol++;
        dwell  = (ds_nxt == ds_cur) ? dwell + 1 : 0;
        ds_cur = ds_nxt;
    end

    task automatic clear_maps();
        for (int i = 0; i < 128; i++) begin
            drive_map[i] = 1'b0;
            model_map[i] = 1'b0;
        end
        inj_tap = -1;
    endtask

    task automatic add_run(input int lo, input int hi);
        for (int i = lo; i <= hi && i < 128; i++) begin
            drive_map[i] = 1'b1;
            model_map[i] = 1'b1;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #2 bus_if.start = 1'b1;
        @(posedge clk); #2 bus_if.start = 1'b0;
    endtask

    // Starts training (optionally a second start mid-run) and waits for done/fail.
    task automatic start_and_wait(input bit extra, output bit timed_out, output bit busy_mid);
        s_inc  = n_inc;
        s_dec  = n_dec;
        s_clr  = n_clr;
        s_viol = n_viol;
        busy_mid = 1'b0;
        pulse_start();
        if (extra) begin
            repeat (40) @(posedge clk);
            #2 busy_mid = bus_if.busy;
            pulse_start();
        end
        timed_out = 1'b1;
        for (int i = 0; i < RUN_BUDGET; i++) begin
            @(posedge clk); #2;
            if (bus_if.done || bus_if.fail) begin
                timed_out = 1'b0;
                break;
            end
        end
        @(posedge clk); #2;
    endtask

    function automatic outcome_t observe();
        outcome_t o;
        o.done  = bus_if.done;
        o.fail  = bus_if.fail;
        o.busy  = bus_if.busy;
        o.width = bus_if.eye_width;
        o.tap   = bus_if.tap_est;
        o.ds    = 7'(ds_cur);
        o.incs  = 8'(n_inc - s_inc);
        o.decs  = 8'(n_dec - s_dec);
        o.clrs  = 8'(n_clr - s_clr);
        o.viols = 8'(n_viol - s_viol);
        return o;
    endfunction

    // Reference: the first maximal run of passing taps at least MIN_EYE long is
    // the eye; the sweep climbs to the tap just past it (or 127) and the tap
    // settles at start + width/2. No such run means a full sweep then a clear.
    function automatic outcome_t expect_model();
        outcome_t e;
        int t = 0;
        int s, w, c, last;
        bit ok = 1'b0;
        w = 0;
        c = 0;
        last = 127;
        while (t < 128 && !ok) begin
            if (model_map[t]) begin
                s = t;
                while (t < 128 && model_map[t]) t++;
                if (t - s >= MIN_EYE) begin
                    ok   = 1'b1;
                    w    = t - s;
                    c    = s + w / 2;
                    last = (t > 127) ? 127 : t;
                end
            end else begin
                t++;
            end
        end
        e.done  = ok;
        e.fail  = !ok;
        e.busy  = 1'b0;
        e.width = ok ? 8'(w) : 8'd0;
        e.tap   = ok ? 7'(c) : 7'd0;
        e.ds    = ok ? 7'(c) : 7'd0;
        e.incs  = 8'(last);
        e.decs  = ok ? 8'(last - c) : 8'd0;
        e.clrs  = ok ? 8'd1 : 8'd2;
        e.viols = 8'd0;
        return e;
    endfunction

    task automatic test_reset();
        logic [18:0] got;
        rst = 1'b1;
        bus_if.start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        got = {bus_if.count, bus_if.ud, bus_if.tap_est, bus_if.eye_width,
               bus_if.busy, bus_if.done, bus_if.fail};
        checks++;
        if (got !== {1'b0, 1'b1, 7'd0, 8'd0, 3'b000}) begin
            failures++;
            $display("FAIL reset_held: got %h want %h", got, {1'b0, 1'b1, 7'd0, 8'd0, 3'b000});
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        got = {bus_if.count, bus_if.ud, bus_if.tap_est, bus_if.eye_width,
               bus_if.busy, bus_if.done, bus_if.fail};
        checks++;
        if (got !== {1'b0, 1'b1, 7'd0, 8'd0, 3'b000}) begin
            failures++;
            $display("FAIL reset_idle: got %h want %h", got, {1'b0, 1'b1, 7'd0, 8'd0, 3'b000});
        end
    endtask

    task automatic test_window();
        bit to, bm;
        outcome_t got, exp;
        clear_maps();
        add_run(40, 59);
        start_and_wait(1'b0, to, bm);
        got = observe();
        exp = expect_model();
        checks++;
        if (to || got !== exp) begin
            failures++;
            $display("FAIL window40: timeout=%0d got %p want %p", to, got, exp);
        end
        checks++;
        if ({got.width, got.tap, got.ds, got.decs} !== {8'd20, 7'd50, 7'd50, 8'd10}) begin
            failures++;
            $display("FAIL window40_centre: width=%0d tap=%0d ds=%0d decs=%0d want 20/50/50/10",
                     got.width, got.tap, got.ds, got.decs);
        end
    endtask

    task automatic test_top_edge();
        bit to, bm;
        outcome_t got, exp;
        clear_maps();
        add_run(100, 127);
        start_and_wait(1'b0, to, bm);
        got = observe();
        exp = expect_model();
        checks++;
        if (to || got !== exp) begin
            failures++;
            $display("FAIL top_edge: timeout=%0d got %p want %p", to, got, exp);
        end
        checks++;
        if ({got.width, got.tap, got.incs, got.decs} !== {8'd28, 7'd114, 8'd127, 8'd13}) begin
            failures++;
            $display("FAIL top_edge_centre: width=%0d tap=%0d incs=%0d decs=%0d want 28/114/127/13",
                     got.width, got.tap, got.incs, got.decs);
        end
    endtask

    task automatic test_no_eye();
        bit to, bm;
        outcome_t got, exp;
        clear_maps();
        start_and_wait(1'b0, to, bm);
        got = observe();
        exp = expect_model();
        checks++;
        if (to || got !== exp) begin
            failures++;
            $display("FAIL no_eye: timeout=%0d got %p want %p", to, got, exp);
        end
        checks++;
        if ({got.fail, got.done, got.tap, got.width, got.incs} !== {2'b10, 7'd0, 8'd0, 8'd127})
        begin
            failures++;
            $display("FAIL no_eye_flags: fail=%0d done=%0d tap=%0d width=%0d incs=%0d",
                     got.fail, got.done, got.tap, got.width, got.incs);
        end
    endtask

    task automatic test_glitch();
        bit to, bm;
        outcome_t got, exp;
        clear_maps();
        add_run(10, 12);
        add_run(30, 45);
        start_and_wait(1'b0, to, bm);
        got = observe();
        exp = expect_model();
        checks++;
        if (to || got !== exp) begin
            failures++;
            $display("FAIL glitch: timeout=%0d got %p want %p", to, got, exp);
        end
        checks++;
        if ({got.width, got.tap} !== {8'd16, 7'd38}) begin
            failures++;
            $display("FAIL glitch_centre: width=%0d tap=%0d want 16/38", got.width, got.tap);
        end
    endtask

    task automatic test_injected();
        bit to, bm;
        outcome_t got, exp;
        clear_maps();
        add_run(40, 59);
        // the counter moves one cycle after the code, so the first sampled word
        // arrives at dwell SETTLE_CYC-1; the last one SAMPLE_CNT-1 words later
        inj_tap   = 40;
        inj_dwell = SETTLE_CYC - 1 + SAMPLE_CNT - 1;
        model_map[40] = 1'b0;
        start_and_wait(1'b0, to, bm);
        got = observe();
        exp = expect_model();
        checks++;
        if (to || got !== exp) begin
            failures++;
            $display("FAIL injected: timeout=%0d got %p want %p", to, got, exp);
        end
        checks++;
        if ({got.width, got.tap} !== {8'd19, 7'd50}) begin
            failures++;
            $display("FAIL injected_centre: width=%0d tap=%0d want 19/50", got.width, got.tap);
        end
        inj_tap = -1;
    endtask

    task automatic test_reset_mid_center();
        bit to, bm, hit;
        int base;
        logic [18:0] got_rst;
        outcome_t got, exp;
        clear_maps();
        add_run(40, 59);
        base = n_dec;
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < RUN_BUDGET; i++) begin
            @(posedge clk); #2;
            if (n_dec - base >= 5) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL reach_center: decrements=%0d want >=5", n_dec - base);
        end
        rst = 1'b1;
        #1;
        got_rst = {bus_if.count, bus_if.ud, bus_if.tap_est, bus_if.eye_width,
                   bus_if.busy, bus_if.done, bus_if.fail};
        checks++;
        if (got_rst !== {1'b0, 1'b1, 7'd0, 8'd0, 3'b000}) begin
            failures++;
            $display("FAIL async_reset: got %h want %h", got_rst, {1'b0, 1'b1, 7'd0, 8'd0, 3'b000});
        end
        bus_if.start = 1'b1;
        @(posedge clk); #2 bus_if.start = 1'b0;
        @(posedge clk); #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({bus_if.busy, bus_if.tap_est} !== {1'b0, 7'd0}) begin
            failures++;
            $display("FAIL post_reset_idle: busy=%0d tap=%0d want 0/0", bus_if.busy, bus_if.tap_est);
        end
        // second start lands while busy and must not restart the sweep
        start_and_wait(1'b1, to, bm);
        got = observe();
        exp = expect_model();
        checks++;
        if (to || !bm || got !== exp) begin
            failures++;
            $display("FAIL start_while_busy: timeout=%0d busy_mid=%0d got %p want %p",
                     to, bm, got, exp);
        end
        start_and_wait(1'b0, to, bm);
        got = observe();
        checks++;
        if (to || got !== exp) begin
            failures++;
            $display("FAIL retrain: timeout=%0d got %p want %p", to, got, exp);
        end
    endtask

    task automatic test_random();
        bit to, bm;
        int s, l, g;
        outcome_t got, exp;
        for (int k = 0; k < 4; k++) begin
            clear_maps();
            s = $urandom_range(0, 127);
            l = $urandom_range(1, 128 - s);
            add_run(s, s + l - 1);
            g = $urandom_range(0, 127);
            add_run(g, g + $urandom_range(0, 3));
            start_and_wait(1'b0, to, bm);
            got = observe();
            exp = expect_model();
            checks++;
            if (to || got !== exp) begin
                failures++;
                $display("FAIL random%0d (run %0d+%0d glitch %0d): timeout=%0d got %p want %p",
                         k, s, l, g, to, got, exp);
            end
        end
    endtask

    initial begin
        bus_if.start   = 1'b0;
        bus_if.data_in = 8'h00;
        test_reset();
        test_window();
        test_top_edge();
        test_no_eye();
        test_glitch();
        test_injected();
        test_reset_mid_center();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
